// File: rtl/add_seq_ctrl_pkg.sv
// Shared types and constants for the multi-word add sequencer.
package add_seq_pkg;

  localparam int WORD_W    = 32;
  localparam int MAX_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add_seq_ctrl_core32.sv
// Combinational 32-bit adder shared by every beat of the sequencer.
module add_core32
  import add_seq_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  logic [WORD_W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};
  assign sum  = full[WORD_W-1:0];
  assign cout = full[WORD_W];

endmodule

// File: rtl/add_seq_ctrl.sv
// WORDS x 32-bit add sequencer: one word per cycle through add_core32, LSW first.
// Optional subtract mode enabled by defining ADD_SEQ_SUB_EN.
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W*WORDS-1:0] a,
  input  logic [WORD_W*WORDS-1:0] b,
  input  logic                    cin,
`ifdef ADD_SEQ_SUB_EN
  input  logic                    sub,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W*WORDS-1:0] s,
  output logic                    cout,
  output logic                    busy
);

  localparam int IDX_W = $clog2(WORDS);

  typedef logic [WORDS-1:0][WORD_W-1:0] vec_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  vec_t             a_q, b_q, s_q, s_d;
  logic [WORD_W-1:0] add_a, add_b, add_sum;
  logic             add_co;
  logic             accept, last, carry_init;

  assign accept = (state_q == IDLE) && in_valid;
  assign last   = (idx_q == IDX_W'(WORDS - 1));

  // Operand words are only read in RUN, so they need no reset.
`ifdef ADD_SEQ_SUB_EN
  logic sub_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sub_q <= sub;
    end
  end

  assign add_b      = sub_q ? ~b_q[idx_q] : b_q[idx_q];
  assign carry_init = sub | cin;
`else
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign add_b      = b_q[idx_q];
  assign carry_init = cin;
`endif

  assign add_a = a_q[idx_q];

  add_core32 u_core (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
  end

  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    s_d     = s_q;
    if (accept) begin
      idx_d   = '0;
      carry_d = carry_init;
    end else if (state_q == RUN) begin
      s_d[idx_q] = add_sum;
      carry_d    = add_co;
      if (last) cout_d = add_co;
      else      idx_d  = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      s_q     <= '0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      s_q     <= s_d;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl (WORDS=4) against a wide-integer model.
module tb_add_seq_ctrl;

  localparam int W  = 4;
  localparam int NB = 32 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] a, b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] s;
  logic          cout;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  add_seq_ctrl #(.WORDS(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADD_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .busy      (busy)
  );

  // Whole-number reference: {cout, s} = a + b + cin, or a - b as a + ~b + 1.
  function automatic logic [NB:0] model(input logic [NB-1:0] ma, mb, input logic mc, ms);
    if (ms) return {1'b0, ma} + {1'b0, ~mb} + (NB+1)'(1);
    return {1'b0, ma} + {1'b0, mb} + (NB+1)'(mc);
  endfunction

  task automatic chk(input string tag, input logic [NB:0] obs, input logic [NB:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [NB-1:0] ta, tbv, input logic tc, ts,
                       input int hold, input string tag);
    logic [NB:0] exp;
    int lat;
    exp = model(ta, tbv, tc, ts);
    @(negedge clk);
    a = ta; b = tbv; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta; b = $urandom; cin = ~tc;
    chk({tag, "_busy_run"}, (NB+1)'(busy), (NB+1)'(1));
    chk({tag, "_in_ready_run"}, (NB+1)'(in_ready), (NB+1)'(0));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, (NB+1)'(lat), (NB+1)'(W));
    chk({tag, "_s"}, (NB+1)'(s), (NB+1)'(exp[NB-1:0]));
    chk({tag, "_cout"}, (NB+1)'(cout), (NB+1)'(exp[NB]));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, (NB+1)'(out_valid), (NB+1)'(1));
      chk({tag, "_hold_s"}, (NB+1)'(s), (NB+1)'(exp[NB-1:0]));
      chk({tag, "_hold_in_ready"}, (NB+1)'(in_ready), (NB+1)'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, (NB+1)'(out_valid), (NB+1)'(0));
    chk({tag, "_in_ready_back"}, (NB+1)'(in_ready), (NB+1)'(1));
    chk({tag, "_idle_busy"}, (NB+1)'(busy), (NB+1)'(0));
  endtask

  initial begin
    logic [NB:0]   q_exp[$];
    logic [NB:0]   e;
    logic [NB-1:0] ra, rb;
    logic          rc;
    int            acc_t[$];
    int            n_acc, n_res, cyc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #23;
    chk("rst_in_ready", (NB+1)'(in_ready), (NB+1)'(1));
    chk("rst_out_valid", (NB+1)'(out_valid), (NB+1)'(0));
    chk("rst_busy", (NB+1)'(busy), (NB+1)'(0));
    chk("rst_s", (NB+1)'(s), (NB+1)'(0));
    chk("rst_cout", (NB+1)'(cout), (NB+1)'(0));
    @(negedge clk); rst_n = 1'b1;

    // Directed cases.
    do_op({NB{1'b1}}, NB'(1), 1'b0, 1'b0, 0, "ones_plus1");
    do_op(NB'(32'hFFFF_FFFF), NB'(1), 1'b0, 1'b0, 0, "word_carry");
    do_op('0, '0, 1'b1, 1'b0, 10, "cin_hold");

    // Random additions.
    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      if (i == 0) rb = ~ra;
      do_op(ra, rb, 1'($urandom), 1'b0, 0, "rand");
    end

`ifdef ADD_SEQ_SUB_EN
    do_op('0, NB'(1), 1'b0, 1'b1, 0, "sub_0m1");
    do_op(NB'(9), NB'(4), 1'b1, 1'b1, 0, "sub_9m4");
`endif

    // Reset asserted during the third RUN cycle.
    @(negedge clk);
    a = {NB{1'b1}}; b = {NB{1'b1}}; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", (NB+1)'(in_ready), (NB+1)'(1));
    chk("midrst_out_valid", (NB+1)'(out_valid), (NB+1)'(0));
    chk("midrst_busy", (NB+1)'(busy), (NB+1)'(0));
    chk("midrst_s", (NB+1)'(s), (NB+1)'(0));
    chk("midrst_cout", (NB+1)'(cout), (NB+1)'(0));
    @(negedge clk); rst_n = 1'b1;
    do_op(NB'(5), NB'(7), 1'b0, 1'b0, 0, "after_rst");

    // Back-to-back with in_valid and out_ready tied high.
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    n_acc = 0; n_res = 0;
    for (cyc = 0; cyc < 60 && n_res < 4; cyc++) begin
      if (out_valid) begin
        e = q_exp.pop_front();
        chk("b2b_s", (NB+1)'(s), (NB+1)'(e[NB-1:0]));
        chk("b2b_cout", (NB+1)'(cout), (NB+1)'(e[NB]));
        n_res++;
      end
      if (in_ready && n_acc < 4) begin
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        rc = 1'($urandom);
        a = ra; b = rb; cin = rc;
        q_exp.push_back(model(ra, rb, rc, 1'b0));
        acc_t.push_back(cyc);
        n_acc++;
      end
      if (n_acc == 4 && !in_ready) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_results", (NB+1)'(n_res), (NB+1)'(4));
    chk("b2b_accepts", (NB+1)'(acc_t.size()), (NB+1)'(4));
    for (int i = 1; i < acc_t.size(); i++)
      chk("b2b_interval", (NB+1)'(acc_t[i] - acc_t[i-1]), (NB+1)'(W + 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
